// File: rtl/gray_disp_pkg.sv
// Shared constants, FSM state type and digit helpers for the Gray digit scan path.
package gray_disp_pkg;

    localparam int unsigned DIG_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StCommit
    } state_e;

    // Reflected Gray code of one BCD digit.
    function automatic logic [DIG_W-1:0] bcd2gray(input logic [DIG_W-1:0] d);
        return d ^ (d >> 1);
    endfunction

    // Double-dabble nibble correction: bump by 3 when the nibble would overflow on shift.
    function automatic logic [DIG_W-1:0] add3(input logic [DIG_W-1:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // 10**n for the elaboration-time range check.
    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/gray_digit_scan_if.sv
// Load handshake and multiplexed display bus of the Gray digit scan block.
interface gray_digit_scan_if
    import gray_disp_pkg::*;
#(
    parameter int unsigned BIN_W = 8,
    parameter int unsigned N_DIG = 3
);

    logic [BIN_W-1:0] bin_in;
    logic             load_valid;
    logic             load_ready;
    logic             conv_done;
    logic [DIG_W-1:0] digito;
    logic [N_DIG-1:0] anodo;

    modport master (
        output bin_in,
        output load_valid,
        input  load_ready,
        input  conv_done,
        input  digito,
        input  anodo
    );

    modport slave (
        input  bin_in,
        input  load_valid,
        output load_ready,
        output conv_done,
        output digito,
        output anodo
    );

endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one shift-and-correct iteration per cycle.
// done_o flags the cycle in which the final iteration is applied; bcd_o is the
// complete result from the following cycle until the next start_i.
module bin_to_bcd_seq
    import gray_disp_pkg::*;
#(
    parameter int unsigned BIN_W = 8,
    parameter int unsigned N_DIG = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [BIN_W-1:0]       bin_i,
    output logic                   done_o,
    output logic [N_DIG*DIG_W-1:0] bcd_o
);

    localparam int unsigned BcdW = N_DIG * DIG_W;
    localparam int unsigned CntW = $clog2(BIN_W + 1);
    localparam logic [CntW-1:0] LastIter = CntW'(BIN_W - 1);

    logic            busy_q, busy_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [BcdW-1:0] scr_q, scr_d, scr_adj;

    // Per-nibble +3 correction of the scratch before it is shifted.
    always_comb begin
        scr_adj = scr_q;
        for (int i = 0; i < N_DIG; i++) begin
            scr_adj[i*DIG_W +: DIG_W] = add3(scr_q[i*DIG_W +: DIG_W]);
        end
    end

    // Start reloads the engine; otherwise iterate once per busy cycle.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        bin_d  = bin_q;
        scr_d  = scr_q;
        if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            bin_d  = bin_i;
            scr_d  = '0;
        end else if (busy_q) begin
            scr_d = {scr_adj[BcdW-2:0], bin_q[BIN_W-1]};
            bin_d = bin_q << 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LastIter) begin
                busy_d = 1'b0;
            end
        end
    end

    // Engine state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            bin_q  <= '0;
            scr_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            bin_q  <= bin_d;
            scr_q  <= scr_d;
        end
    end

    assign done_o = busy_q && (cnt_q == LastIter);
    assign bcd_o  = scr_q;

endmodule

// File: rtl/gray_digit_scan.sv
// Binary-to-Gray digit scanner: load handshake, BCD conversion, committed display
// register and a free-running scan that drives one shared Gray bus plus anodes.
module gray_digit_scan
    import gray_disp_pkg::*;
#(
    parameter int unsigned BIN_W    = 8,
    parameter int unsigned N_DIG    = 3,
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    gray_digit_scan_if.slave  bus
);

    localparam int unsigned BcdW = N_DIG * DIG_W;
    localparam int unsigned IdxW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int unsigned PreW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PreW-1:0] PreLast = PreW'(SCAN_DIV - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(N_DIG - 1);

    if (pow10(N_DIG) <= ((64'd1 << BIN_W) - 64'd1)) begin : g_range_chk
        $fatal(1, "gray_digit_scan: N_DIG digits cannot hold every BIN_W-bit value");
    end
    if (SCAN_DIV < 1) begin : g_div_chk
        $fatal(1, "gray_digit_scan: SCAN_DIV must be at least 1");
    end

    state_e           state_q, state_d;
    logic             eng_start, eng_done;
    logic [BcdW-1:0]  eng_bcd;
    logic [BcdW-1:0]  disp_q, disp_d;
    logic [PreW-1:0]  pre_q, pre_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [N_DIG-1:0] anodo_q, anodo_d;
    logic [DIG_W-1:0] digito_q, digito_d;
    logic             load_ready, conv_done;

    bin_to_bcd_seq #(
        .BIN_W (BIN_W),
        .N_DIG (N_DIG)
    ) u_bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (eng_start),
        .bin_i   (bus.bin_in),
        .done_o  (eng_done),
        .bcd_o   (eng_bcd)
    );

    // Handshake FSM: accept in idle, wait for the engine, commit for one cycle.
    always_comb begin
        state_d    = state_q;
        eng_start  = 1'b0;
        load_ready = 1'b0;
        conv_done  = 1'b0;
        unique case (state_q)
            StIdle: begin
                load_ready = 1'b1;
                if (bus.load_valid) begin
                    eng_start = 1'b1;
                    state_d   = StShift;
                end
            end
            StShift: begin
                if (eng_done) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                conv_done = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Display only changes on commit; scan prescaler and index run freely.
    always_comb begin
        disp_d = (state_q == StCommit) ? eng_bcd : disp_q;
        pre_d  = pre_q + 1'b1;
        idx_d  = idx_q;
        if (pre_q == PreLast) begin
            pre_d = '0;
            idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
        end
        anodo_d  = ~(N_DIG'(1) << idx_q);
        digito_d = bcd2gray(disp_q[idx_q*DIG_W +: DIG_W]);
    end

    // Display, scan and output registers; anode and digit always move together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_q   <= '0;
            pre_q    <= '0;
            idx_q    <= '0;
            anodo_q  <= '1;
            digito_q <= '0;
        end else begin
            disp_q   <= disp_d;
            pre_q    <= pre_d;
            idx_q    <= idx_d;
            anodo_q  <= anodo_d;
            digito_q <= digito_d;
        end
    end

    assign bus.load_ready = load_ready;
    assign bus.conv_done  = conv_done;
    assign bus.anodo      = anodo_q;
    assign bus.digito     = digito_q;

endmodule

// File: tb/tb_gray_digit_scan.sv
// Self-checking bench for gray_digit_scan: per-cycle comparison against a
// value-level model plus hand-computed digit/latency checks.
module tb_gray_digit_scan;

    localparam int unsigned BIN_W    = 8;
    localparam int unsigned N_DIG    = 3;
    localparam int unsigned SCAN_DIV = 4;

    logic clk;
    logic rst_n;

    gray_digit_scan_if #(.BIN_W(BIN_W), .N_DIG(N_DIG)) bus ();

    gray_digit_scan #(
        .BIN_W    (BIN_W),
        .N_DIG    (N_DIG),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gray code of each decimal digit, written out by hand.
    logic [3:0] gray_tab [10] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                  4'b0111, 4'b0101, 4'b0100, 4'b1100, 4'b1101};

    int n_cmp = 0;
    int n_err = 0;

    // Model state: committed value, value in flight, cycles left until idle.
    int         m_tick, m_busy, m_disp, m_pend, m_pos;
    bit         m_live = 1'b0;
    logic [2:0] e_an;
    logic [3:0] e_dig;
    logic       e_ready, e_done;

    function automatic int dec_digit(input int v, input int p);
        int r = v;
        for (int i = 0; i < p; i++) r = r / 10;
        return r % 10;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic load(input logic [7:0] v);
        int n = 0;
        while (bus.load_ready !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("load_ready_wait", {31'd0, bus.load_ready}, 32'd1);
        bus.bin_in     = v;
        bus.load_valid = 1'b1;
        @(negedge clk);
        bus.load_valid = 1'b0;
    endtask

    // Called on the first negedge after the accept edge (cycle 1).
    task automatic wait_done(output int n);
        n = 1;
        while (bus.conv_done !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("conv_done_seen", {31'd0, bus.conv_done}, 32'd1);
    endtask

    task automatic check_digits(input logic [3:0] g0, input logic [3:0] g1,
                                input logic [3:0] g2);
        logic [3:0] g [3];
        logic [2:0] an;
        int n;
        g[0] = g0;
        g[1] = g1;
        g[2] = g2;
        repeat (2) @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            an = ~(3'b001 << p);
            n  = 0;
            while (bus.anodo !== an && n < 20) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("anode_found_%0d", p), {29'd0, bus.anodo}, {29'd0, an});
            check($sformatf("digit_%0d", p), {28'd0, bus.digito}, {28'd0, g[p]});
        end
    endtask

    initial begin
        int lat, pulses, n, run;
        rst_n          = 1'b0;
        bus.load_valid = 1'b0;
        bus.bin_in     = '0;

        fork
            // Model: advances on every rising edge from the sampled inputs.
            forever begin
                @(posedge clk);
                if (!rst_n) begin
                    m_tick = 0;
                    m_busy = 0;
                    m_disp = 0;
                    m_pend = 0;
                    e_an   = 3'b111;
                    e_dig  = 4'b0000;
                    m_live = 1'b1;
                end else begin
                    m_pos = (m_tick / SCAN_DIV) % N_DIG;
                    e_an  = ~(3'b001 << m_pos);
                    e_dig = gray_tab[dec_digit(m_disp, m_pos)];
                    m_tick++;
                    if (m_busy == 1) begin
                        m_disp = m_pend;
                        m_busy = 0;
                    end else if (m_busy > 1) begin
                        m_busy--;
                    end else if (bus.load_valid) begin
                        m_pend = int'(bus.bin_in);
                        m_busy = BIN_W + 1;
                    end
                end
                e_ready = (m_busy == 0);
                e_done  = (m_busy == 1);
            end
            // Per-cycle comparison away from the active edge.
            forever begin
                @(negedge clk);
                if (m_live) begin
                    check("cyc_load_ready", {31'd0, bus.load_ready}, {31'd0, e_ready});
                    check("cyc_conv_done", {31'd0, bus.conv_done}, {31'd0, e_done});
                    check("cyc_anodo", {29'd0, bus.anodo}, {29'd0, e_an});
                    check("cyc_digito", {28'd0, bus.digito}, {28'd0, e_dig});
                end
            end
            begin
                #50000;
                $display("FAIL watchdog: simulation did not finish in time");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset held for three cycles, then released.
        repeat (3) @(negedge clk);
        check("rst_anodo", {29'd0, bus.anodo}, 32'd7);
        check("rst_digito", {28'd0, bus.digito}, 32'd0);
        check("rst_load_ready", {31'd0, bus.load_ready}, 32'd1);
        check("rst_conv_done", {31'd0, bus.conv_done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_anodo", {29'd0, bus.anodo}, 32'd6);
        check("first_digito", {28'd0, bus.digito}, 32'd0);

        // 237: nine-cycle latency, digits 7/3/2, each held SCAN_DIV cycles.
        repeat (2) @(negedge clk);
        load(8'd237);
        wait_done(lat);
        check("latency_237", lat, 32'd9);
        check_digits(4'b0100, 4'b0010, 4'b0011);
        n = 0;
        while (bus.anodo !== 3'b101 && n < 20) begin
            @(negedge clk);
            n++;
        end
        run = 0;
        while (bus.anodo === 3'b101 && run < 10) begin
            @(negedge clk);
            run++;
        end
        check("hold_len_pos1", run, 32'd4);

        // Boundary values.
        load(8'd0);
        wait_done(lat);
        check_digits(4'b0000, 4'b0000, 4'b0000);
        load(8'd255);
        wait_done(lat);
        check_digits(4'b0111, 4'b0111, 4'b0011);
        load(8'd9);
        wait_done(lat);
        check_digits(4'b1101, 4'b0000, 4'b0000);

        // A request during conversion is dropped.
        load(8'd100);
        @(negedge clk);
        bus.bin_in     = 8'd200;
        bus.load_valid = 1'b1;
        repeat (3) @(negedge clk);
        bus.load_valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.conv_done === 1'b1) pulses++;
            @(negedge clk);
        end
        check("busy_single_done", pulses, 32'd1);
        check_digits(4'b0000, 4'b0000, 4'b0001);

        // Reset in the fourth shift cycle aborts the conversion.
        load(8'd237);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready", {31'd0, bus.load_ready}, 32'd1);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.conv_done === 1'b1) pulses++;
            @(negedge clk);
        end
        check("abort_no_done", pulses, 32'd0);
        check_digits(4'b0000, 4'b0000, 4'b0000);

        // Back-to-back: valid held, new value presented the cycle after conv_done.
        bus.bin_in     = 8'd45;
        bus.load_valid = 1'b1;
        @(negedge clk);
        wait_done(lat);
        @(negedge clk);
        bus.bin_in = 8'd46;
        check("b2b_ready_back", {31'd0, bus.load_ready}, 32'd1);
        @(negedge clk);
        bus.load_valid = 1'b0;
        check("b2b_second_accept", {31'd0, bus.load_ready}, 32'd0);
        wait_done(lat);
        check("latency_46", lat, 32'd9);
        check_digits(4'b0101, 4'b0110, 4'b0000);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
